// File: rtl/q_result_tx.sv
// Buffers finished charge results and ships each one as a 4-byte 8N1 packet:
// header, high byte, low byte, XOR checksum.
module q_result_tx #(
  parameter int         BUS_WIDTH    = 10,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          q_valid,
  input  logic [BUS_WIDTH-1:0]          q_data,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              TW      = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   T_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, NEXT} state_t;

  function automatic logic [7:0] checksum(input logic [7:0] hi, input logic [7:0] lo);
    return HEADER ^ hi ^ lo;
  endfunction

  state_t         state_q, state_d;
  logic           v1, v2, push_req;
  logic [15:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           full, pop, push_ok, drop;
  logic [15:0]    head;
  logic [7:0]     pkt [4];
  logic [TW-1:0]  timer;
  logic [2:0]     bit_idx;
  logic [1:0]     byte_idx;
  logic           t_last;

  // Capture stage: edge detect, then push one cycle later so q_data has settled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      push_req <= 1'b0;
    end else begin
      v1       <= q_valid;
      v2       <= v1;
      push_req <= v1 & ~v2;
    end
  end

  // FIFO stage: a pop frees a slot in the same cycle, so a full push still lands
  assign full    = (fifo_count == DEPTH_C);
  assign pop     = (state_q == LOAD);
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= 16'(q_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Transmit stage: packet is latched at LOAD and indexed byte/bit on the wire
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      pkt[0] <= HEADER;
      pkt[1] <= head[15:8];
      pkt[2] <= head[7:0];
      pkt[3] <= checksum(head[15:8], head[7:0]);
    end
  end

  assign t_last = (timer == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      if (state_q inside {START, DATA, STOP}) timer <= t_last ? '0 : timer + 1'b1;
      else                                    timer <= '0;
      if (state_q == DATA) begin
        if (t_last) bit_idx <= bit_idx + 1'b1;
      end else begin
        bit_idx <= '0;
      end
      if (state_q == LOAD)                            byte_idx <= '0;
      else if (state_q == NEXT && byte_idx != 2'd3)   byte_idx <= byte_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_count != '0) state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (t_last) state_d = DATA;
      DATA:    if (t_last && bit_idx == 3'd7) state_d = STOP;
      STOP:    if (t_last) state_d = NEXT;
      NEXT:    state_d = (byte_idx != 2'd3) ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state_q != IDLE);
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = pkt[byte_idx][bit_idx];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_q_result_tx.sv
// Bench for q_result_tx: directed results, expected bytes queued at issue time,
// a UART decoder on tx pops and compares each received byte.
module tb_q_result_tx;
  localparam int BW  = 10;
  localparam int FD  = 4;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          q_valid = 1'b0;
  logic [BW-1:0] q_data = '0;
  logic          clr_ovf = 1'b0;
  logic          tx, busy, overflow;
  logic [2:0]    fifo_count;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    exp_q [$];

  logic [9:0]    mon_bits;
  bit            mon_ok, mon_abort;
  logic [7:0]    mon_exp;

  q_result_tx #(
    .BUS_WIDTH(BW), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_data(q_data), .clr_ovf(clr_ovf),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  task automatic push_pkt(input logic [BW-1:0] val);
    logic [15:0] q16;
    q16 = 16'(val);
    push_bytes(8'hA5, q16[15:8], q16[7:0], 8'hA5 ^ q16[15:8] ^ q16[7:0]);
  endtask

  task automatic send(input logic [BW-1:0] val, input bit expect_it);
    if (expect_it) push_pkt(val);
    q_data  = val;
    q_valid = 1'b1;
    repeat (2) @(negedge clk);
    q_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int stable;
    int n;
    stable = 0;
    n = 0;
    while (stable < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && fifo_count == 3'd0) stable++;
      else stable = 0;
    end
    check("idle_timeout", 32'(stable >= 3), 1);
    check("bytes_pending", exp_q.size(), 0);
  endtask

  task automatic wait_tx_low();
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_timeout", 32'(tx === 1'b0), 1);
  endtask

  // Monitor: every bit must hold CPB cycles; compare decoded byte against queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_ok    = 1'b1;
        mon_abort = 1'b0;
        for (int b = 0; b < 10 && !mon_abort; b++) begin
          for (int c = 0; c < CPB && !mon_abort; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (rst) mon_abort = 1'b1;
            else if (c == 0) mon_bits[b] = tx;
            else if (tx !== mon_bits[b]) mon_ok = 1'b0;
          end
        end
        if (!mon_abort) begin
          check("frame", 32'(mon_ok && mon_bits[0] == 1'b0 && mon_bits[9] == 1'b1), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", mon_bits[8:1]);
          end else begin
            mon_exp = exp_q.pop_front();
            check("byte", 32'(mon_bits[8:1]), 32'(mon_exp));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int max_cnt;
    int low_seen;

    // Reset state, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_count", 32'(fifo_count), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single packet with hand-computed bytes
    push_bytes(8'hA5, 8'h02, 8'hD3, 8'h74);
    send(10'h2D3, 1'b0);
    wait_idle(3000);
    check("single_busy_end", 32'(busy), 0);
    check("single_overflow", 32'(overflow), 0);

    // Held level: exactly one push
    push_bytes(8'hA5, 8'h00, 8'hAB, 8'h0E);
    q_data  = 10'h0AB;
    q_valid = 1'b1;
    max_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    q_valid = 1'b0;
    wait_idle(3000);
    check("held_peak_count", max_cnt, 1);

    // Overflow: 1 in flight + 4 buffered, the sixth is dropped
    for (int i = 0; i < 6; i++) send(10'h101 + 10'(i), i < 5);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count_full", 32'(fifo_count), 4);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);
    wait_idle(3000);

    // Pointer wrap: ten sequential results
    for (int i = 0; i < 10; i++) begin
      send(10'(i), 1'b1);
      wait_idle(3000);
    end

    // Full FIFO with a push landing in the LOAD cycle
    send(10'h3F0, 1'b1);
    wait_tx_low();
    for (int i = 1; i < 5; i++) send(10'h3F0 + 10'(i), 1'b1);
    repeat (147) @(negedge clk);
    check("full_before", 32'(fifo_count), 4);
    send(10'h3F5, 1'b1);
    check("full_pushpop_count", 32'(fifo_count), 4);
    check("full_pushpop_ovf", 32'(overflow), 0);
    wait_idle(3000);

    // Reset during data bit 3 of the high byte
    send(10'h2F0, 1'b1);
    wait_tx_low();
    send(10'h111, 1'b0);
    repeat (54) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 0);
    check("pre_rst_count", 32'(fifo_count), 1);
    rst = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_count", 32'(fifo_count), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    low_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1;
    end
    check("post_rst_quiet", low_seen, 0);
    send(10'h1C7, 1'b1);
    wait_idle(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
